alucu_md_seq: RTL and testbench
===============================

Name: alucu_md_seq

Overview:
Parametrised successor to the ALU control unit for the multicycle MIPS core.
- Decodes ALUOP and funct into a registered ALU control code.
- Adds a multiply/divide sequencer. It starts the iterative MDU, stalls the datapath for a programmable latency, and pulses the HI/LO write enable on completion.
- Sits between the main control FSM and the ALU/MDU.

Parameters:
- AOP_W, 5, width of the ALUOP input.
- FN_W, 6, width of the funct field.
- CTRL_W, 5, width of the ALU control output; must be ≥5.
- MUL_LAT, 4, busy cycles for MULT/MULTU; must be ≥1.
- DIV_LAT, 32, busy cycles for DIV/DIVU; must be ≥1.
- CNT_W, 6, counter width; must satisfy 2^CNT_W > max(MUL_LAT, DIV_LAT).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- valid  in  1  issue strobe from the control FSM.
- ALUOP  in  AOP_W  ALU operation class.
- funccode  in  FN_W  instruction funct field.
- ALUOPCtrl  out  CTRL_W  registered ALU control code.
- md_start  out  1  one-cycle MDU start pulse.
- md_op  out  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU; held while busy.
- stall  out  1  high while an MDU op is in flight.
- hilo_we  out  1  one-cycle HI/LO write pulse.
- illegal  out  1  undecodable op (see Optional Feature).

Behaviour:
- Reset (asynchronous, immediate) sets ALUOPCtrl=0x1F (NOP), md_start=0, md_op=0, stall=0, hilo_we=0, illegal=0, state=IDLE, counter=0.
- ALUOP encodings: 0x00 ADD, 0x01 SUB, 0x02 RTYPE, 0x03 AND, 0x04 OR, 0x05 SLT, 0x06 XOR, 0x07 LUI. Others are undefined.
- ALUOPCtrl codes: ADD 00, ADDU 01, SUB 02, SUBU 03, AND 04, OR 05, XOR 06, NOR 07, SLT 08, SLTU 09, SLL 0A, SRL 0B, SRA 0C, LUI 0D, NOP 1F.
- RTYPE funct map: 20→00, 21→01, 22→02, 23→03, 24→04, 25→05, 26→06, 27→07, 2A→08, 2B→09, 00→0A, 02→0B, 03→0C. MFHI(10), MFLO(12), MULT/DIV(18–1B) and unknown → 1F.
- Non-RTYPE ALUOP map: 00→00, 01→02, 03→04, 04→05, 05→08, 06→06, 07→0D, undefined→1F.
- ALUOPCtrl latency: 1 cycle. It is registered every posedge from the current inputs, independent of valid and of stall.
- FSM states: IDLE, BUSY, DONE.
- IDLE: on valid && ALUOP==RTYPE && funct∈{18,19,1A,1B}:
  - md_start=1 for exactly one cycle.
  - md_op latched: 18→0, 19→1, 1A→2, 1B→3.
  - counter loaded with LAT−1, where LAT is MUL_LAT for ops 0/1 and DIV_LAT for ops 2/3.
  - stall=1.
  - Next state BUSY.
- BUSY:
  - stall=1.
  - Counter decrements each cycle.
  - When the counter is 0, next state is DONE.
  - valid is ignored; upstream holds the instruction.
- DONE: hilo_we=1 and stall=0 for one cycle, then next state IDLE.
- DONE with valid and an MDU funct present: the new op is not accepted in that cycle. It is accepted in the following IDLE cycle.
- Stall timing: stall goes high the cycle after issue. Total stall length is LAT+1 cycles; hilo_we asserts in the cycle stall drops.
- md_op is held until the next start.
- Reset mid-operation: immediate return to IDLE, with no hilo_we pulse.

Optional Feature:
- Macro: ALUCU_ILLEGAL_EN.
- Defined: illegal is registered with 1-cycle latency and is 1 when valid is high and either:
  - ALUOP is undefined, or
  - ALUOP==RTYPE and funct is outside the mapped/MDU/MFHI/MFLO set.
  When illegal asserts, no md_start is issued.
- Undefined: illegal is tied to 0, and undecodable ops silently yield NOP.

Decomposition:
- Package alucu_pkg holds:
  - ALUOP localparams.
  - funct localparams.
  - ALUOPCtrl codes.
  - md_op codes.
  - the FSM state encoding.
- The decode logic stays in alucu_md_seq.
- Sub-module md_seq holds the FSM plus counter. Its interface is clk, rst, go, op, start, busy, done, op_q, parameterised by MUL_LAT, DIV_LAT and CNT_W.

Test Plan:
1. Vector file sweep with defaults: lines "funccode ALUOP expected" (e.g. 20 02 00, 2A 02 08, 00 01 02, 00 07 0D) → ALUOPCtrl matches on the next posedge for every line.
2. MULT: valid=1, ALUOP=02, funct=18 → md_start pulses 1 cycle, md_op=0, stall high for 5 cycles (MUL_LAT=4), hilo_we pulses exactly when stall drops.
3. DIVU with DIV_LAT=32 → md_op=3, stall high for 33 cycles, single hilo_we pulse, then IDLE.
4. Back-to-back: during DONE present DIV → no start that cycle; md_start fires the next cycle with md_op=2.
5. Reset asserted at BUSY cycle 10 of a DIV → all outputs return to reset values immediately, no hilo_we, ALUOPCtrl=1F.
6. With ALUCU_ILLEGAL_EN: valid, ALUOP=02, funct=3F → illegal=1 next cycle, ALUOPCtrl=1F, md_start stays 0. Without the macro, illegal stays 0.

Source files
------------

// File: rtl/alucu_pkg.sv
// Shared encodings for the ALU control unit and its multiply/divide sequencer:
// ALUOP classes, funct codes, ALU control codes, md_op codes and FSM states.
package alucu_pkg;

  localparam logic [7:0] AOP_ADD   = 8'h00;
  localparam logic [7:0] AOP_SUB   = 8'h01;
  localparam logic [7:0] AOP_RTYPE = 8'h02;
  localparam logic [7:0] AOP_AND   = 8'h03;
  localparam logic [7:0] AOP_OR    = 8'h04;
  localparam logic [7:0] AOP_SLT   = 8'h05;
  localparam logic [7:0] AOP_XOR   = 8'h06;
  localparam logic [7:0] AOP_LUI   = 8'h07;

  localparam logic [7:0] FN_SLL   = 8'h00;
  localparam logic [7:0] FN_SRL   = 8'h02;
  localparam logic [7:0] FN_SRA   = 8'h03;
  localparam logic [7:0] FN_MFHI  = 8'h10;
  localparam logic [7:0] FN_MFLO  = 8'h12;
  localparam logic [7:0] FN_MULT  = 8'h18;
  localparam logic [7:0] FN_MULTU = 8'h19;
  localparam logic [7:0] FN_DIV   = 8'h1A;
  localparam logic [7:0] FN_DIVU  = 8'h1B;
  localparam logic [7:0] FN_ADD   = 8'h20;
  localparam logic [7:0] FN_ADDU  = 8'h21;
  localparam logic [7:0] FN_SUB   = 8'h22;
  localparam logic [7:0] FN_SUBU  = 8'h23;
  localparam logic [7:0] FN_AND   = 8'h24;
  localparam logic [7:0] FN_OR    = 8'h25;
  localparam logic [7:0] FN_XOR   = 8'h26;
  localparam logic [7:0] FN_NOR   = 8'h27;
  localparam logic [7:0] FN_SLT   = 8'h2A;
  localparam logic [7:0] FN_SLTU  = 8'h2B;

  localparam logic [4:0] C_ADD  = 5'h00;
  localparam logic [4:0] C_ADDU = 5'h01;
  localparam logic [4:0] C_SUB  = 5'h02;
  localparam logic [4:0] C_SUBU = 5'h03;
  localparam logic [4:0] C_AND  = 5'h04;
  localparam logic [4:0] C_OR   = 5'h05;
  localparam logic [4:0] C_XOR  = 5'h06;
  localparam logic [4:0] C_NOR  = 5'h07;
  localparam logic [4:0] C_SLT  = 5'h08;
  localparam logic [4:0] C_SLTU = 5'h09;
  localparam logic [4:0] C_SLL  = 5'h0A;
  localparam logic [4:0] C_SRL  = 5'h0B;
  localparam logic [4:0] C_SRA  = 5'h0C;
  localparam logic [4:0] C_LUI  = 5'h0D;
  localparam logic [4:0] C_NOP  = 5'h1F;

  localparam logic [1:0] MD_MULT  = 2'd0;
  localparam logic [1:0] MD_MULTU = 2'd1;
  localparam logic [1:0] MD_DIV   = 2'd2;
  localparam logic [1:0] MD_DIVU  = 2'd3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/md_seq.sv
// Multiply/divide sequencer: launches the MDU, holds busy for LAT+1 cycles,
// then raises done for one cycle before returning to idle.
module md_seq
  import alucu_pkg::*;
#(
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned DIV_LAT = 32,
  parameter int unsigned CNT_W   = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic [1:0] op,
  output logic       start,
  output logic       busy,
  output logic       done,
  output logic [1:0] op_q
);

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             start_q, start_d;
  logic [1:0]       op_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start_d = 1'b0;
    op_d    = op_q;
    case (state_q)
      ST_IDLE: begin
        if (go) begin
          state_d = ST_BUSY;
          start_d = 1'b1;
          op_d    = op;
          cnt_d   = op[1] ? DIV_LOAD : MUL_LOAD;
        end
      end
      ST_BUSY: begin
        // The launch cycle itself is not counted, giving LAT+1 busy cycles.
        if (!start_q) begin
          if (cnt_q == '0) state_d = ST_DONE;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      start_q <= 1'b0;
      op_q    <= MD_MULT;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      op_q    <= op_d;
    end
  end

  assign start = start_q;
  assign busy  = (state_q == ST_BUSY);
  assign done  = (state_q == ST_DONE);

endmodule

// File: rtl/alucu_md_seq.sv
// ALU control decoder with registered control code plus MDU sequencer.
// Optional ALUCU_ILLEGAL_EN macro enables the registered illegal-op flag.
module alucu_md_seq
  import alucu_pkg::*;
#(
  parameter int unsigned AOP_W   = 5,
  parameter int unsigned FN_W    = 6,
  parameter int unsigned CTRL_W  = 5,
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned DIV_LAT = 32,
  parameter int unsigned CNT_W   = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic [AOP_W-1:0]  ALUOP,
  input  logic [FN_W-1:0]   funccode,
  output logic [CTRL_W-1:0] ALUOPCtrl,
  output logic              md_start,
  output logic [1:0]        md_op,
  output logic              stall,
  output logic              hilo_we,
  output logic              illegal
);

  logic [CTRL_W-1:0] ctrl_d, ctrl_q;
  logic              is_rtype, is_md_fn, go;

  assign is_rtype = (ALUOP == AOP_W'(AOP_RTYPE));
  assign is_md_fn = (funccode >= FN_W'(FN_MULT)) && (funccode <= FN_W'(FN_DIVU));

  always_comb begin
    ctrl_d = CTRL_W'(C_NOP);
    case (ALUOP)
      AOP_W'(AOP_ADD): ctrl_d = CTRL_W'(C_ADD);
      AOP_W'(AOP_SUB): ctrl_d = CTRL_W'(C_SUB);
      AOP_W'(AOP_AND): ctrl_d = CTRL_W'(C_AND);
      AOP_W'(AOP_OR):  ctrl_d = CTRL_W'(C_OR);
      AOP_W'(AOP_SLT): ctrl_d = CTRL_W'(C_SLT);
      AOP_W'(AOP_XOR): ctrl_d = CTRL_W'(C_XOR);
      AOP_W'(AOP_LUI): ctrl_d = CTRL_W'(C_LUI);
      AOP_W'(AOP_RTYPE): begin
        case (funccode)
          FN_W'(FN_ADD):  ctrl_d = CTRL_W'(C_ADD);
          FN_W'(FN_ADDU): ctrl_d = CTRL_W'(C_ADDU);
          FN_W'(FN_SUB):  ctrl_d = CTRL_W'(C_SUB);
          FN_W'(FN_SUBU): ctrl_d = CTRL_W'(C_SUBU);
          FN_W'(FN_AND):  ctrl_d = CTRL_W'(C_AND);
          FN_W'(FN_OR):   ctrl_d = CTRL_W'(C_OR);
          FN_W'(FN_XOR):  ctrl_d = CTRL_W'(C_XOR);
          FN_W'(FN_NOR):  ctrl_d = CTRL_W'(C_NOR);
          FN_W'(FN_SLT):  ctrl_d = CTRL_W'(C_SLT);
          FN_W'(FN_SLTU): ctrl_d = CTRL_W'(C_SLTU);
          FN_W'(FN_SLL):  ctrl_d = CTRL_W'(C_SLL);
          FN_W'(FN_SRL):  ctrl_d = CTRL_W'(C_SRL);
          FN_W'(FN_SRA):  ctrl_d = CTRL_W'(C_SRA);
          default:        ctrl_d = CTRL_W'(C_NOP);
        endcase
      end
      default: ctrl_d = CTRL_W'(C_NOP);
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ctrl_q <= CTRL_W'(C_NOP);
    else     ctrl_q <= ctrl_d;
  end

  assign ALUOPCtrl = ctrl_q;

`ifdef ALUCU_ILLEGAL_EN
  logic ill_d, ill_q;

  // Anything decoding to NOP is illegal unless it is an MDU or HI/LO move.
  assign ill_d = valid && (ctrl_d == CTRL_W'(C_NOP)) &&
                 !(is_rtype && (is_md_fn ||
                                funccode == FN_W'(FN_MFHI) ||
                                funccode == FN_W'(FN_MFLO)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ill_q <= 1'b0;
    else     ill_q <= ill_d;
  end

  assign illegal = ill_q;
  assign go      = valid && is_rtype && is_md_fn && !ill_d;
`else
  assign illegal = 1'b0;
  assign go      = valid && is_rtype && is_md_fn;
`endif

  // funct 0x18..0x1B map directly onto md_op 0..3 via their low bits.
  md_seq #(
    .MUL_LAT(MUL_LAT),
    .DIV_LAT(DIV_LAT),
    .CNT_W  (CNT_W)
  ) u_md_seq (
    .clk  (clk),
    .rst  (rst),
    .go   (go),
    .op   (funccode[1:0]),
    .start(md_start),
    .busy (stall),
    .done (hilo_we),
    .op_q (md_op)
  );

endmodule

// File: tb/tb_alucu_md_seq.sv
// Directed self-checking bench for alucu_md_seq with default parameters.
module tb_alucu_md_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid;
  logic [4:0] ALUOP;
  logic [5:0] funccode;
  logic [4:0] ALUOPCtrl;
  logic       md_start;
  logic [1:0] md_op;
  logic       stall;
  logic       hilo_we;
  logic       illegal;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alucu_md_seq #(
    .AOP_W  (5),
    .FN_W   (6),
    .CTRL_W (5),
    .MUL_LAT(4),
    .DIV_LAT(32),
    .CNT_W  (6)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .valid    (valid),
    .ALUOP    (ALUOP),
    .funccode (funccode),
    .ALUOPCtrl(ALUOPCtrl),
    .md_start (md_start),
    .md_op    (md_op),
    .stall    (stall),
    .hilo_we  (hilo_we),
    .illegal  (illegal)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] aop, input logic [5:0] fn);
    valid    = v;
    ALUOP    = aop;
    funccode = fn;
  endtask

  // After the issue edge: wait for stall to drop, checking length and pulses.
  task automatic finish_md(input string tag, input int lat);
    int n, starts, early;
    n = 1; starts = 0; early = 0;
    while (stall && n < 200) begin
      step();
      if (md_start) starts++;
      if (stall) begin
        n++;
        if (hilo_we) early++;
      end
    end
    chk({tag, "_stall_len"}, 32'(n), 32'(lat + 1));
    chk({tag, "_extra_start"}, 32'(starts), 32'd0);
    chk({tag, "_early_hilo"}, 32'(early), 32'd0);
    chk({tag, "_hilo"}, hilo_we, 1'b1);
    step();
    chk({tag, "_hilo_off"}, hilo_we, 1'b0);
    chk({tag, "_idle_stall"}, stall, 1'b0);
  endtask

  task automatic run_md(input string tag, input logic [5:0] fn, input logic [1:0] op, input int lat);
    drive(1'b1, 5'h02, fn);
    step();
    chk({tag, "_start"}, md_start, 1'b1);
    chk({tag, "_op"}, md_op, op);
    chk({tag, "_stall0"}, stall, 1'b1);
    drive(1'b0, 5'h00, 6'h00);
    finish_md(tag, lat);
  endtask

  // {funccode, ALUOP, expected ALUOPCtrl}
  logic [23:0] vec [26] = '{
    24'h20_02_00, 24'h21_02_01, 24'h22_02_02, 24'h23_02_03, 24'h24_02_04,
    24'h25_02_05, 24'h26_02_06, 24'h27_02_07, 24'h2A_02_08, 24'h2B_02_09,
    24'h00_02_0A, 24'h02_02_0B, 24'h03_02_0C, 24'h10_02_1F, 24'h12_02_1F,
    24'h18_02_1F, 24'h3F_02_1F, 24'h00_00_00, 24'h00_01_02, 24'h00_03_04,
    24'h00_04_05, 24'h00_05_08, 24'h00_06_06, 24'h00_07_0D, 24'h00_08_1F,
    24'h00_1F_1F
  };

  initial begin
    logic [23:0] v;
    int k, hl;

    rst = 1'b1;
    drive(1'b0, 5'h00, 6'h00);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctrl", ALUOPCtrl, 5'h1F);
    chk("rst_start", md_start, 1'b0);
    chk("rst_op", md_op, 2'd0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_hilo", hilo_we, 1'b0);
    chk("rst_ill", illegal, 1'b0);
    rst = 1'b0;

    // Decode sweep with valid low so no MDU op is launched.
    for (int i = 0; i < 26; i++) begin
      v = vec[i];
      drive(1'b0, v[12:8], v[21:16]);
      step();
      chk($sformatf("dec%0d", i), ALUOPCtrl, v[4:0]);
      chk($sformatf("dec%0d_start", i), md_start, 1'b0);
    end

    // Valid non-MDU R-type: decodes, no start, not illegal.
    drive(1'b1, 5'h02, 6'h20);
    step();
    chk("add_valid_ctrl", ALUOPCtrl, 5'h00);
    chk("add_valid_start", md_start, 1'b0);
    chk("add_valid_ill", illegal, 1'b0);
    drive(1'b0, 5'h00, 6'h00);
    step();

    run_md("mult", 6'h18, 2'd0, 4);
    run_md("divu", 6'h1B, 2'd3, 32);

    // Back-to-back: DIV presented during DONE is taken the following cycle.
    drive(1'b1, 5'h02, 6'h19);
    step();
    chk("b2b_start1", md_start, 1'b1);
    chk("b2b_op1", md_op, 2'd1);
    drive(1'b0, 5'h00, 6'h00);
    k = 0;
    while (!hilo_we && k < 50) begin
      step();
      k++;
    end
    chk("b2b_done", hilo_we, 1'b1);
    drive(1'b1, 5'h02, 6'h1A);
    step();
    chk("b2b_nostart", md_start, 1'b0);
    chk("b2b_nostall", stall, 1'b0);
    chk("b2b_op_held", md_op, 2'd1);
    step();
    chk("b2b_start2", md_start, 1'b1);
    chk("b2b_op2", md_op, 2'd2);
    chk("b2b_stall2", stall, 1'b1);
    drive(1'b0, 5'h00, 6'h00);
    finish_md("b2b_div", 32);

    // Reset in the middle of a DIV.
    drive(1'b1, 5'h02, 6'h1A);
    step();
    chk("rdiv_start", md_start, 1'b1);
    drive(1'b0, 5'h07, 6'h00);
    repeat (10) step();
    chk("rdiv_busy", stall, 1'b1);
    chk("rdiv_op", md_op, 2'd2);
    chk("rdiv_ctrl_busy", ALUOPCtrl, 5'h0D);
    #2 rst = 1'b1;
    #1;
    chk("rdiv_rst_stall", stall, 1'b0);
    chk("rdiv_rst_op", md_op, 2'd0);
    chk("rdiv_rst_start", md_start, 1'b0);
    chk("rdiv_rst_hilo", hilo_we, 1'b0);
    chk("rdiv_rst_ctrl", ALUOPCtrl, 5'h1F);
    step();
    rst = 1'b0;
    drive(1'b0, 5'h00, 6'h00);
    hl = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (hilo_we || stall) hl++;
    end
    chk("rdiv_no_hilo", 32'(hl), 32'd0);

    // Undecodable R-type funct with valid.
    drive(1'b1, 5'h02, 6'h3F);
    step();
    chk("ill_ctrl", ALUOPCtrl, 5'h1F);
    chk("ill_start", md_start, 1'b0);
`ifdef ALUCU_ILLEGAL_EN
    chk("ill_flag", illegal, 1'b1);
    drive(1'b1, 5'h09, 6'h00);
    step();
    chk("ill_aop_flag", illegal, 1'b1);
    drive(1'b1, 5'h02, 6'h10);
    step();
    chk("ill_mfhi_flag", illegal, 1'b0);
    drive(1'b0, 5'h02, 6'h3F);
    step();
    chk("ill_novalid_flag", illegal, 1'b0);
`else
    chk("ill_flag_off", illegal, 1'b0);
`endif
    drive(1'b0, 5'h00, 6'h00);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
